// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and helpers for the systolic-array operand feeder
package mm_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } feeder_state_t;

    // Base bit offset of lane idx within a packed N-lane bus.
    function automatic int lane_slice(input int idx, input int width = DEFAULT_DATA_WIDTH);
        return idx * width;
    endfunction

endpackage

// File: rtl/mm_skew_line.sv
// rtl/mm_skew_line.sv - fixed-depth delay line carrying one lane's data and valid bit
module mm_skew_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] shift_data,
    input  logic                  shift_valid,
    output logic [DATA_WIDTH-1:0] tap_data,
    output logic                  tap_valid
);

    logic [DATA_WIDTH-1:0] data_sr [DEPTH];
    logic [DEPTH-1:0]      valid_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_sr[k] <= '0;
            end
            valid_sr <= '0;
        end else begin
            data_sr[0]  <= shift_data;
            valid_sr[0] <= shift_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_sr[k]  <= data_sr[k-1];
                valid_sr[k] <= valid_sr[k-1];
            end
        end
    end

    assign tap_data  = data_sr[DEPTH-1];
    assign tap_valid = valid_sr[DEPTH-1];

endmodule

// File: rtl/mm_operand_feeder.sv
// rtl/mm_operand_feeder.sv - skewed operand feeder for one array edge; MM_FEEDER_UNDERRUN_EN enables the sticky underrun flag
module mm_operand_feeder
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N          = 4,
    parameter int K_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [K_W-1:0]          k_len_i,
    input  logic                    col_valid_i,
    output logic                    col_ready_o,
    input  logic [N*DATA_WIDTH-1:0] col_data_i,
    output logic [N*DATA_WIDTH-1:0] a_o,
    output logic [N-1:0]            lane_valid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int FW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 2);

    feeder_state_t  state;
    logic [K_W-1:0] k_len;
    logic [K_W-1:0] k_cnt;
    logic [FW-1:0]  f_cnt;
    logic           accept;

    assign col_ready_o = (state == STREAM);
    assign busy_o      = (state != IDLE);
    assign accept      = col_ready_o & col_valid_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            k_len  <= '0;
            k_cnt  <= '0;
            f_cnt  <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (k_len_i != '0) begin
                            k_len <= k_len_i;
                            k_cnt <= '0;
                            state <= STREAM;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // Underrun cycles still count: the array cannot be stalled.
                    if (k_cnt == k_len - K_W'(1)) begin
                        f_cnt <= '0;
                        state <= FLUSH;
                    end else begin
                        k_cnt <= k_cnt + K_W'(1);
                    end
                end
                FLUSH: begin
                    if (f_cnt == FLUSH_LAST) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        f_cnt <= f_cnt + FW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MM_FEEDER_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_o <= 1'b0;
        end else if (state == IDLE && start_i && k_len_i != '0) begin
            err_o <= 1'b0;
        end else if (state == STREAM && !col_valid_i) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    // Lane i delays by i+1 cycles; zeros shift in whenever no column is taken.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int LO = lane_slice(i, DATA_WIDTH);
        logic [DATA_WIDTH-1:0] lane_in;

        assign lane_in = accept ? col_data_i[LO +: DATA_WIDTH] : '0;

        mm_skew_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (i + 1)
        ) u_skew (
            .clk        (clk),
            .reset      (reset),
            .shift_data (lane_in),
            .shift_valid(accept),
            .tap_data   (a_o[LO +: DATA_WIDTH]),
            .tap_valid  (lane_valid_o[i])
        );
    end

endmodule

// File: tb/tb_mm_operand_feeder.sv
// tb/tb_mm_operand_feeder.sv - self-checking bench for mm_operand_feeder
module tb_mm_operand_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;
`ifdef MM_FEEDER_UNDERRUN_EN
    localparam bit UNDERRUN_EN = 1'b1;
`else
    localparam bit UNDERRUN_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]   due;
        logic [DW-1:0] d;
        logic          v;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_i;
    logic [KW-1:0]   k_len_i;
    logic            col_valid_i;
    logic            col_ready_o;
    logic [N*DW-1:0] col_data_i;
    logic [N*DW-1:0] a_o;
    logic [N-1:0]    lane_valid_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq [N][$];

    always #5 clk = ~clk;

    mm_operand_feeder #(
        .DATA_WIDTH(DW),
        .N         (N),
        .K_W       (KW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .col_valid_i (col_valid_i),
        .col_ready_o (col_ready_o),
        .col_data_i  (col_data_i),
        .a_o         (a_o),
        .lane_valid_o(lane_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    task automatic test_reset();
        reset       = 1'b1;
        start_i     = 1'b1;
        k_len_i     = 8'd3;
        col_valid_i = 1'b1;
        col_data_i  = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_o, lane_valid_o, col_ready_o, busy_o, done_o, err_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got a=%h lv=%b rdy/busy/done/err=%b%b%b%b want all 0",
                     a_o, lane_valid_o, col_ready_o, busy_o, done_o, err_o);
        end
        reset       = 1'b0;
        start_i     = 1'b0;
        k_len_i     = '0;
        col_valid_i = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] cols [3];
        logic [3:0]  want;
        exp_t        e;
        cols[0] = 32'h04030201;
        cols[1] = 32'h08070605;
        cols[2] = 32'h0C0B0A09;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            want = {c >= 1 && c <= 3, c >= 1 && c <= 6, c == 7, 1'b0};
            n_checks++;
            if ({col_ready_o, busy_o, done_o, err_o} !== want) begin
                n_errors++;
                $display("FAIL basic_ctrl c=%0d: got rdy/busy/done/err=%b want %b",
                         c, {col_ready_o, busy_o, done_o, err_o}, want);
            end
            for (int i = 0; i < N; i++) begin
                e = '0;
                if (sbq[i].size() != 0 && sbq[i][0].due == c) e = sbq[i].pop_front();
                n_checks++;
                if (a_o[i*DW +: DW] !== e.d || lane_valid_o[i] !== e.v) begin
                    n_errors++;
                    $display("FAIL basic_lane%0d c=%0d: got %h/%b want %h/%b",
                             i, c, a_o[i*DW +: DW], lane_valid_o[i], e.d, e.v);
                end
            end
            start_i     = (c == 0);
            k_len_i     = 8'd3;
            col_valid_i = (c >= 1 && c <= 3);
            col_data_i  = col_valid_i ? cols[c-1] : $urandom;
            if (col_valid_i) begin
                for (int i = 0; i < N; i++) sbq[i].push_back({32'(c + 1 + i), cols[c-1][i*DW +: DW], 1'b1});
            end
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (sbq[i].size() != 0) begin
                n_errors++;
                $display("FAIL basic_drain lane%0d: got %0d pending want 0", i, sbq[i].size());
            end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] cols [3];
        logic [3:0]  want;
        exp_t        e;
        cols[0] = 32'h04030201;
        cols[1] = 32'h08070605;
        cols[2] = 32'h0C0B0A09;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            want = {c >= 1 && c <= 3, c >= 1 && c <= 6, c == 7, UNDERRUN_EN && c >= 3};
            n_checks++;
            if ({col_ready_o, busy_o, done_o, err_o} !== want) begin
                n_errors++;
                $display("FAIL underrun_ctrl c=%0d: got rdy/busy/done/err=%b want %b",
                         c, {col_ready_o, busy_o, done_o, err_o}, want);
            end
            for (int i = 0; i < N; i++) begin
                e = '0;
                if (sbq[i].size() != 0 && sbq[i][0].due == c) e = sbq[i].pop_front();
                n_checks++;
                if (a_o[i*DW +: DW] !== e.d || lane_valid_o[i] !== e.v) begin
                    n_errors++;
                    $display("FAIL underrun_lane%0d c=%0d: got %h/%b want %h/%b",
                             i, c, a_o[i*DW +: DW], lane_valid_o[i], e.d, e.v);
                end
            end
            start_i     = (c == 0);
            k_len_i     = 8'd3;
            col_valid_i = (c == 1 || c == 3);
            col_data_i  = (c >= 1 && c <= 3) ? cols[c-1] : $urandom;
            if (c >= 1 && c <= 3) begin
                for (int i = 0; i < N; i++)
                    sbq[i].push_back({32'(c + 1 + i), col_valid_i ? cols[c-1][i*DW +: DW] : 8'h00, col_valid_i});
            end
        end
    endtask

    task automatic test_start_ignored_restart();
        logic [3:0]  want;
        logic [31:0] col;
        exp_t        e;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            want = {(c >= 1 && c <= 3) || c == 8 || c == 9,
                    (c >= 1 && c <= 6) || (c >= 8 && c <= 12),
                    c == 7 || c == 13,
                    UNDERRUN_EN && c == 0};
            n_checks++;
            if ({col_ready_o, busy_o, done_o, err_o} !== want) begin
                n_errors++;
                $display("FAIL restart_ctrl c=%0d: got rdy/busy/done/err=%b want %b",
                         c, {col_ready_o, busy_o, done_o, err_o}, want);
            end
            for (int i = 0; i < N; i++) begin
                e = '0;
                if (sbq[i].size() != 0 && sbq[i][0].due == c) e = sbq[i].pop_front();
                n_checks++;
                if (a_o[i*DW +: DW] !== e.d || lane_valid_o[i] !== e.v) begin
                    n_errors++;
                    $display("FAIL restart_lane%0d c=%0d: got %h/%b want %h/%b",
                             i, c, a_o[i*DW +: DW], lane_valid_o[i], e.d, e.v);
                end
            end
            start_i     = (c == 0 || c == 2 || c == 4 || c == 7);
            k_len_i     = (c == 7) ? 8'd2 : (c == 0) ? 8'd3 : 8'd7;
            col_valid_i = (c >= 1 && c <= 3) || c == 8 || c == 9;
            col         = $urandom;
            col_data_i  = col;
            if (col_valid_i) begin
                for (int i = 0; i < N; i++) sbq[i].push_back({32'(c + 1 + i), col[i*DW +: DW], 1'b1});
            end
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (sbq[i].size() != 0) begin
                n_errors++;
                $display("FAIL restart_drain lane%0d: got %0d pending want 0", i, sbq[i].size());
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0]  want;
        logic [31:0] col;
        exp_t        e;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            want = {(c >= 1 && c <= 3) || c == 6 || c == 7,
                    (c >= 1 && c <= 3) || (c >= 6 && c <= 10),
                    c == 11,
                    1'b0};
            n_checks++;
            if ({col_ready_o, busy_o, done_o, err_o} !== want) begin
                n_errors++;
                $display("FAIL abort_ctrl c=%0d: got rdy/busy/done/err=%b want %b",
                         c, {col_ready_o, busy_o, done_o, err_o}, want);
            end
            for (int i = 0; i < N; i++) begin
                e = '0;
                if (sbq[i].size() != 0 && sbq[i][0].due == c) e = sbq[i].pop_front();
                n_checks++;
                if (a_o[i*DW +: DW] !== e.d || lane_valid_o[i] !== e.v) begin
                    n_errors++;
                    $display("FAIL abort_lane%0d c=%0d: got %h/%b want %h/%b",
                             i, c, a_o[i*DW +: DW], lane_valid_o[i], e.d, e.v);
                end
            end
            reset       = (c == 3);
            start_i     = (c == 0 || c == 5);
            k_len_i     = (c == 0) ? 8'd5 : 8'd2;
            col_valid_i = (c >= 1 && c <= 3) || c == 6 || c == 7;
            col         = $urandom;
            col_data_i  = col;
            if (c == 3) begin
                for (int i = 0; i < N; i++) sbq[i].delete();
            end else if (col_valid_i) begin
                for (int i = 0; i < N; i++) sbq[i].push_back({32'(c + 1 + i), col[i*DW +: DW], 1'b1});
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_len();
        logic [3:0] want;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            want = {1'b0, 1'b0, c == 1, 1'b0};
            n_checks++;
            if ({col_ready_o, busy_o, done_o, err_o} !== want || lane_valid_o !== '0 || a_o !== '0) begin
                n_errors++;
                $display("FAIL zero_len c=%0d: got rdy/busy/done/err=%b lv=%b a=%h want %b lv=0 a=0",
                         c, {col_ready_o, busy_o, done_o, err_o}, lane_valid_o, a_o, want);
            end
            start_i     = (c == 0);
            k_len_i     = 8'd0;
            col_valid_i = (c <= 3);
            col_data_i  = $urandom;
        end
    endtask

    task automatic test_single_column();
        logic [3:0]  want;
        logic [31:0] col;
        exp_t        e;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            want = {c == 1, c >= 1 && c <= 4, c == 5, 1'b0};
            n_checks++;
            if ({col_ready_o, busy_o, done_o, err_o} !== want) begin
                n_errors++;
                $display("FAIL single_ctrl c=%0d: got rdy/busy/done/err=%b want %b",
                         c, {col_ready_o, busy_o, done_o, err_o}, want);
            end
            for (int i = 0; i < N; i++) begin
                e = '0;
                if (sbq[i].size() != 0 && sbq[i][0].due == c) e = sbq[i].pop_front();
                n_checks++;
                if (a_o[i*DW +: DW] !== e.d || lane_valid_o[i] !== e.v) begin
                    n_errors++;
                    $display("FAIL single_lane%0d c=%0d: got %h/%b want %h/%b",
                             i, c, a_o[i*DW +: DW], lane_valid_o[i], e.d, e.v);
                end
            end
            start_i     = (c == 0);
            k_len_i     = 8'd1;
            col_valid_i = (c == 1);
            col         = $urandom;
            col_data_i  = col;
            if (col_valid_i) begin
                for (int i = 0; i < N; i++) sbq[i].push_back({32'(c + 1 + i), col[i*DW +: DW], 1'b1});
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        start_i     = 1'b0;
        k_len_i     = '0;
        col_valid_i = 1'b0;
        col_data_i  = '0;
        test_reset();
        test_basic();
        test_underrun();
        test_start_ignored_restart();
        test_reset_abort();
        test_zero_len();
        test_single_column();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
